// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered read data, occupancy and threshold flags.
// Optional sticky Overflow/Underflow error flags are built when FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Clear,
    input  logic                  Write,
    input  logic [DATA_WIDTH-1:0] Data_In,
    input  logic                  Read,
    output logic [DATA_WIDTH-1:0] Data_Out,
    output logic                  Data_Valid,
    output logic [3:0]            Fifo_Status,
    output logic [ADDR_WIDTH:0]   Level,
    output logic                  Overflow,
    output logic                  Underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_L  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_L = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   wr_ptr_nxt;
    logic [ADDR_WIDTH:0]   rd_ptr_nxt;
    logic [ADDR_WIDTH:0]   level_nxt;
    logic [3:0]            status_q;
    logic                  empty;
    logic                  full;
    logic                  wr_acc;
    logic                  rd_acc;

    // Handshake: Write is taken when there is room (or a same-cycle read frees a slot), Read is
    // taken when non-empty; a rejected request is dropped, not held, and Data_Valid marks each taken read.
    assign empty  = status_q[0];
    assign full   = status_q[1];
    assign wr_acc = Write && (!full || Read);
    assign rd_acc = Read && !empty;

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (Clear) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else begin
            if (wr_acc) wr_ptr_nxt = wr_ptr + 1'b1;
            if (rd_acc) rd_ptr_nxt = rd_ptr + 1'b1;
        end
        level_nxt = wr_ptr_nxt - rd_ptr_nxt;
    end

    always_ff @(posedge Clk) begin
        if (wr_acc && !Clear) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= Data_In;
        end
    end

    // Flags are registered from the post-edge level so they never see Read/Write combinationally.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            Data_Out   <= '0;
            Data_Valid <= 1'b0;
            status_q   <= 4'b1001;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            Data_Valid <= rd_acc && !Clear;
            if (rd_acc && !Clear) begin
                Data_Out <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
            status_q <= {(level_nxt <= AEMPTY_L), (level_nxt >= AFULL_L),
                         (level_nxt == DEPTH_L), (level_nxt == '0)};
        end
    end

    assign Level       = wr_ptr - rd_ptr;
    assign Fifo_Status = status_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q;
    logic unf_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (Clear) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (Write && !wr_acc) ovf_q <= 1'b1;
            if (Read && !rd_acc)  unf_q <= 1'b1;
        end
    end

    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
`else
    assign Overflow  = 1'b0;
    assign Underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: directed scenarios plus random traffic against a queue-based model.
module tb_sync_fifo_param;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Clear = 1'b0;
    logic       Write = 1'b0;
    logic [7:0] Data_In = 8'h00;
    logic       Read = 1'b0;
    logic [7:0] Data_Out;
    logic       Data_Valid;
    logic [3:0] Fifo_Status;
    logic [4:0] Level;
    logic       Overflow;
    logic       Underflow;

`ifdef FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    sync_fifo_param dut (
        .Clk(Clk), .Reset(Reset), .Clear(Clear), .Write(Write), .Data_In(Data_In),
        .Read(Read), .Data_Out(Data_Out), .Data_Valid(Data_Valid),
        .Fifo_Status(Fifo_Status), .Level(Level), .Overflow(Overflow), .Underflow(Underflow)
    );

    initial forever #5 Clk = ~Clk;

    // Reference model: the FIFO contents as a queue plus the visible registered outputs.
    logic [7:0] exp_q[$];
    logic [7:0] exp_dout;
    logic       exp_valid;
    logic       exp_ovf;
    logic       exp_unf;
    int         checks;
    int         failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        int n;
        n = exp_q.size();
        chk({tag, "_level"}, 32'(Level), 32'(n));
        chk({tag, "_status"}, 32'(Fifo_Status),
            32'({(n <= 2), (n >= 14), (n == 16), (n == 0)}));
        chk({tag, "_dout"}, 32'(Data_Out), 32'(exp_dout));
        chk({tag, "_valid"}, 32'(Data_Valid), 32'(exp_valid));
        chk({tag, "_ovf"}, 32'(Overflow), 32'(exp_ovf & ERR_EN));
        chk({tag, "_unf"}, 32'(Underflow), 32'(exp_unf & ERR_EN));
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_dout  = 8'h00;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
    endtask

    // One clock with the given requests; model updated at the edge, outputs checked 1ns later.
    task automatic cycle(input logic w, input logic r, input logic [7:0] d, input logic c,
                         input string tag);
        bit wr_ok, rd_ok;
        @(negedge Clk);
        Write = w; Read = r; Data_In = d; Clear = c;
        @(posedge Clk);
        if (c) begin
            exp_q.delete();
            exp_valid = 1'b0;
            exp_ovf   = 1'b0;
            exp_unf   = 1'b0;
        end else begin
            wr_ok = w && (exp_q.size() < 16 || r);
            rd_ok = r && (exp_q.size() > 0);
            if (w && !wr_ok) exp_ovf = 1'b1;
            if (r && !rd_ok) exp_unf = 1'b1;
            exp_valid = rd_ok;
            if (rd_ok) exp_dout = exp_q.pop_front();
            if (wr_ok) exp_q.push_back(d);
        end
        #1;
        chk_all(tag);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        #12;
        chk_all("reset_init");
        Reset = 1'b0;

        // 1: reset pulse mid-stream takes effect between edges
        for (int i = 0; i < 5; i++) cycle(1'b1, (i > 2), 8'(8'h50 + i), 1'b0, "pre_rst");
        @(negedge Clk);
        Write = 1'b0; Read = 1'b0;
        #2 Reset = 1'b1;
        #1;
        model_reset();
        chk_all("rst_mid");
        #1 Reset = 1'b0;

        // 2: fill with 00..0F then drain in order
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(i), 1'b0, "fill");
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0, "drain");

        // 3: simultaneous write+read when full
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(i), 1'b0, "fill3");
        cycle(1'b1, 1'b1, 8'hA5, 1'b0, "full_wr_rd");
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0, "drain3");
        chk("a5_last", 32'(Data_Out), 32'h0000_00A5);

        // 4: simultaneous write+read when empty, no fall-through
        cycle(1'b1, 1'b1, 8'h3C, 1'b0, "empty_wr_rd");
        cycle(1'b0, 1'b1, 8'h00, 1'b0, "read_3c");
        chk("got_3c", 32'(Data_Out), 32'h0000_003C);

        // 5: overflow, underflow, clear
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(8'h80 + i), 1'b0, "fill5");
        cycle(1'b1, 1'b0, 8'hFF, 1'b0, "overflow");
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0, "drain5");
        cycle(1'b0, 1'b1, 8'h00, 1'b0, "underflow");
        cycle(1'b1, 1'b1, 8'h77, 1'b1, "clear");
        cycle(1'b0, 1'b0, 8'h00, 1'b0, "idle");

        // 6: wrap with interleaved traffic at level 3
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(i), 1'b0, "pre_wrap");
        for (int i = 3; i < 43; i++) cycle(1'b1, 1'b1, 8'(i), 1'b0, "wrap");
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0, "post_wrap");

        // random traffic with occasional clear
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 40) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
